// File: rtl/bytewrite_ram_arb_pkg.sv
// Shared types and helpers for the byte-write RAM port arbiter.
// The flattened request buses are sliced with fld_lsb().
package bytewrite_ram_arb_pkg;

    typedef enum logic {INIT, RUN} state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int IDX_W       = $clog2(DEF_NUM_REQ);

    function automatic int fld_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bytewrite_ram_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request at or
// above ptr_i, wrapping past the top index.
module bytewrite_ram_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    always_comb begin
        int  j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[IW'(j)]) begin
                found             = 1'b1;
                grant_o[IW'(j)]   = 1'b1;
                idx_o             = IW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/bytewrite_ram_port_arbiter.sv
// Round-robin arbiter sharing one byte-write BRAM port among NUM_REQ clients,
// with an optional zero-fill sweep after reset and tagged read returns.
module bytewrite_ram_port_arbiter
    import bytewrite_ram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int NUM_COL       = 4,
    parameter int COL_WIDTH     = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = NUM_COL * COL_WIDTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*NUM_COL-1:0]      req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            init_done,
    output logic                            ram_ena,
    output logic [NUM_COL-1:0]              ram_we,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout
);

    localparam int     IW        = $clog2(NUM_REQ);
    localparam state_e RST_STATE = INIT_ON_RESET ? INIT : RUN;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                   ram_ena_q, ram_ena_d;
    logic [NUM_COL-1:0]     ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]  ram_din_q, ram_din_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [IW-1:0]          rd_idx_q, rd_idx_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                   init_done_q, init_done_d;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   accept;
    logic [NUM_COL-1:0]     sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    bytewrite_ram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grants open one cycle after the state reaches RUN, so no request can
    // be accepted while the last sweep write is still on the RAM port.
    assign req_ready = init_done_q ? pick_grant : '0;
    assign accept    = init_done_q & pick_any;

    always_comb begin
        sel_we    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_we    = req_we[fld_lsb(i, NUM_COL) +: NUM_COL];
                sel_addr  = req_addr[fld_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                sel_wdata = req_wdata[fld_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        ram_ena_d   = 1'b0;
        ram_we_d    = '0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        rd_vld_d    = 1'b0;
        rd_idx_d    = rd_idx_q;
        rsp_valid_d = '0;
        init_done_d = (state_q == RUN);
        if (rd_vld_q) begin
            rsp_valid_d[rd_idx_q] = 1'b1;
        end
        case (state_q)
            INIT: begin
                ram_ena_d  = 1'b1;
                ram_we_d   = '1;
                ram_din_d  = '0;
                ram_addr_d = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    ram_ena_d  = 1'b1;
                    ram_we_d   = sel_we;
                    ram_addr_d = sel_addr;
                    ram_din_d  = sel_wdata;
                    rr_ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    rd_vld_d   = (sel_we == '0);
                    rd_idx_d   = pick_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            ram_ena_q   <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            rsp_valid_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ram_ena_q   <= ram_ena_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            rsp_valid_q <= rsp_valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign ram_ena   = ram_ena_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = ram_dout;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_bytewrite_ram_port_arbiter.sv
// Scoreboard bench for bytewrite_ram_port_arbiter: a driver predicts grants and
// read results from a word-level memory model; a monitor checks each response.
module tb_bytewrite_ram_port_arbiter;

    localparam int N  = 4;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam int AW = 4;
    localparam int DW = NC * CW;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*NC-1:0] req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, ram_din, ram_dout;
    logic            init_done, ram_ena;
    logic [NC-1:0]   ram_we;
    logic [AW-1:0]   ram_addr;

    logic [N-1:0]  d_valid;
    logic [NC-1:0] d_we[N];
    logic [AW-1:0] d_addr[N];
    logic [DW-1:0] d_wdata[N];

    always_comb begin
        req_valid = d_valid;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_we[i*NC +: NC]    = d_we[i];
            req_addr[i*AW +: AW]  = d_addr[i];
            req_wdata[i*DW +: DW] = d_wdata[i];
        end
    end

    bytewrite_ram_port_arbiter #(
        .NUM_REQ       (N),
        .NUM_COL       (NC),
        .COL_WIDTH     (CW),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .ram_ena   (ram_ena),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Byte-write BRAM port in NO_CHANGE mode: writes leave dout untouched.
    logic [DW-1:0] tb_mem[DEPTH];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_we == '0) begin
                ram_dout <= tb_mem[ram_addr];
            end else begin
                for (int b = 0; b < NC; b++)
                    if (ram_we[b]) tb_mem[ram_addr][b*CW +: CW] <= ram_din[b*CW +: CW];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_mem[DEPTH];
    int            m_ptr = 0;
    bit            m_run = 1'b0;
    int            last_grant = -1;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_ram_ena", ram_ena, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_req_ready", req_ready, 0);
    endtask

    task automatic set_req(input int i, input logic [NC-1:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        d_we[i]    = we;
        d_addr[i]  = a;
        d_wdata[i] = d;
    endtask

    task automatic rand_fields(input int i, input bit read_only);
        logic [NC-1:0] we;
        we = (read_only || $urandom_range(0, 1) == 0) ? '0 : NC'($urandom_range(1, 15));
        set_req(i, we, AW'($urandom_range(0, DEPTH - 1)), $urandom);
    endtask

    // One cycle of traffic: inputs are already set; predict the grant from the
    // rotation order starting at the model pointer and apply it to the memory model.
    task automatic run_cycle();
        int            g;
        int            j;
        logic [N-1:0]  exp_rdy;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (m_run) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && d_valid[j]) g = j;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("grant", req_ready, exp_rdy);
        last_grant = g;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (d_we[g] == '0) begin
                sbq.push_back('{g, ref_mem[d_addr[g]], cyc + 2});
            end else begin
                for (int b = 0; b < NC; b++)
                    if (d_we[g][b]) ref_mem[d_addr[g]][b*CW +: CW] = d_wdata[g][b*CW +: CW];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        d_valid = '0;
        sbq.delete();
        m_ptr = 0;
        m_run = 1'b0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
    endtask

    // Zero-fill sweep check; stop_at >= 0 asserts rst mid-cycle at that address.
    task automatic sweep(input int stop_at);
        d_valid = '1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check("sweep_ena", ram_ena, 1);
            check("sweep_we", ram_we, 4'hF);
            check("sweep_din", ram_din, 0);
            check("sweep_addr", ram_addr, k);
            check("sweep_ready", req_ready, 0);
            check("sweep_init_done", init_done, 0);
            if (k == stop_at) begin
                #2;
                rst = 1'b1;
                sbq.delete();
                #1;
                check_reset_vals();
                return;
            end
        end
        @(posedge clk);
        #1;
        d_valid = '0;
        @(negedge clk);
        check("init_done_set", init_done, 1);
        check("post_sweep_ena", ram_ena, 0);
        check("post_sweep_ready", req_ready, 0);
        m_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid != '0) begin
                    if (sbq.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = sbq.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        check("rsp_valid", rsp_valid, oh);
                        check("rsp_rdata", rsp_rdata, e.data);
                        check("rsp_cycle", cyc, e.cyc);
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    e = sbq.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("rsp_missing", rsp_valid, oh);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        d_valid = '0;
        for (int i = 0; i < N; i++) set_req(i, '0, '0, '0);

        apply_reset();
        sweep(-1);

        // Byte-masked write then read-after-write from requester 2.
        set_req(2, 4'b0101, 4'd5, 32'hAABBCCDD);
        d_valid = 4'b0100;
        run_cycle();
        set_req(2, 4'b0000, 4'd5, 32'h0);
        run_cycle();
        d_valid = '0;
        repeat (3) run_cycle();

        // Move pointer to 0, then all four hold reads continuously.
        rand_fields(3, 1'b1);
        d_valid = 4'b1000;
        run_cycle();
        for (int i = 0; i < N; i++) rand_fields(i, 1'b1);
        d_valid = '1;
        repeat (8) begin
            run_cycle();
            if (last_grant >= 0) rand_fields(last_grant, 1'b1);
        end
        d_valid = '0;
        repeat (3) run_cycle();

        // Pointer to 2, then only requesters 1 and 3 active.
        rand_fields(1, 1'b1);
        d_valid = 4'b0010;
        run_cycle();
        rand_fields(1, 1'b1);
        rand_fields(3, 1'b1);
        d_valid = 4'b1010;
        repeat (3) begin
            run_cycle();
            if (last_grant >= 0) rand_fields(last_grant, 1'b1);
        end
        d_valid = '0;
        repeat (3) run_cycle();

        // Random traffic; a requester keeps its fields until granted.
        for (int i = 0; i < N; i++) rand_fields(i, 1'b0);
        repeat (400) begin
            run_cycle();
            for (int i = 0; i < N; i++) begin
                if (!d_valid[i] || i == last_grant) begin
                    d_valid[i] = ($urandom_range(0, 99) < 60);
                    rand_fields(i, 1'b0);
                end
            end
        end
        d_valid = '0;
        repeat (3) run_cycle();

        // Ensure address 5 holds nonzero data, then reset with a read in flight.
        set_req(0, 4'hF, 4'd5, 32'h12345678);
        d_valid = 4'b0001;
        run_cycle();
        set_req(1, 4'h0, 4'd5, 32'h0);
        d_valid = 4'b0010;
        run_cycle();
        rst = 1'b1;
        sbq.delete();
        d_valid = '0;
        repeat (3) begin
            @(negedge clk);
            check("rsp_after_rst", rsp_valid, 0);
        end

        apply_reset();
        sweep(7);
        apply_reset();
        sweep(-1);

        set_req(0, 4'h0, 4'd5, 32'h0);
        d_valid = 4'b0001;
        run_cycle();
        d_valid = '0;
        repeat (4) run_cycle();

        check("sbq_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
